// File: rtl/frost32_irq_ctrl_pkg.sv
// Shared types and defaults for the Frost32 interrupt controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package PkgFrost32IrqCtrl;

   localparam int DEF_NUM_SOURCES    = 8;
   localparam int DEF_HOLDOFF_CYCLES = 2;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   localparam int MAX_ID_WIDTH       = 5;
   localparam int CNT_WIDTH          = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLDOFF
   } StateIrqCtrl;

   // Registered request towards the CPU; sized for the widest legal source count.
   typedef struct packed {
      logic                    interrupt;
      logic                    timeout_pulse;
      logic [MAX_ID_WIDTH-1:0] irq_id;
   } PortOut_Frost32IrqCtrl;

endpackage

// File: rtl/frost32_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt sources.
// Latency: combinational.
// Backpressure: none.
module frost32_irq_prio_enc #(
   parameter int NUM_SOURCES = 8,
   parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
   input  logic [NUM_SOURCES-1:0] req,
   output logic                   valid,
   output logic [ID_WIDTH-1:0]    id
);

   always_comb begin
      valid = |req;
      id    = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (req[i]) id = ID_WIDTH'(i);
      end
   end

endmodule

// File: rtl/frost32_irq_ctrl.sv
// Edge-latching, maskable interrupt controller feeding Frost32Cpu; optional timeout via FROST32_IRQ_CTRL_TIMEOUT_EN.
// Latency: source edge at t gives pending at t+1 and interrupt at t+2.
// Backpressure: wait_for_mem blocks new requests only; a live request is held until irq_ack.
module frost32_irq_ctrl
   import PkgFrost32IrqCtrl::*;
#(
   parameter int                     NUM_SOURCES    = DEF_NUM_SOURCES,
   parameter int                     ID_WIDTH       = $clog2(NUM_SOURCES),
   parameter int                     HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter logic [NUM_SOURCES-1:0] MASK_RESET     = '1,
   parameter int                     TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SOURCES-1:0] src_irq,
   input  logic                   wait_for_mem,
   input  logic                   irq_ack,
   input  logic                   mask_we,
   input  logic [NUM_SOURCES-1:0] mask_wdata,
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
   output logic                   timeout_pulse,
`endif
   output logic                   interrupt,
   output logic [ID_WIDTH-1:0]    irq_id,
   output logic [NUM_SOURCES-1:0] pending,
   output logic [NUM_SOURCES-1:0] mask
);

   StateIrqCtrl            state_q, state_n;
   logic [CNT_WIDTH-1:0]   hold_q, hold_n;
   PortOut_Frost32IrqCtrl  out_q, out_n;
   logic [NUM_SOURCES-1:0] src_q, src_edge, clr, cand;
   logic                   cand_vld, ack_ok, req_done;
   logic [ID_WIDTH-1:0]    cand_id;
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
   logic [CNT_WIDTH-1:0]   tmo_q, tmo_n;
`else
   logic                   unused_tmo;
   localparam int          unused_timeout_cycles = TIMEOUT_CYCLES;
   assign unused_tmo = out_q.timeout_pulse;
`endif

   assign src_edge = src_irq & ~src_q;
   assign cand     = pending & mask;
   assign clr      = ack_ok ? (NUM_SOURCES'(1) << out_q.irq_id) : '0;

   frost32_irq_prio_enc #(
      .NUM_SOURCES(NUM_SOURCES),
      .ID_WIDTH   (ID_WIDTH)
   ) u_prio_enc (
      .req  (cand),
      .valid(cand_vld),
      .id   (cand_id)
   );

   always_comb begin
      state_n             = state_q;
      hold_n              = hold_q;
      out_n               = out_q;
      out_n.timeout_pulse = 1'b0;
      ack_ok              = 1'b0;
      req_done            = 1'b0;
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
      tmo_n               = '0;
`endif
      case (state_q)
         IDLE: begin
            if (cand_vld && !wait_for_mem) begin
               state_n         = REQ;
               out_n.interrupt = 1'b1;
               out_n.irq_id    = MAX_ID_WIDTH'(cand_id);
            end
         end
         REQ: begin
            req_done = irq_ack;
            ack_ok   = irq_ack;
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
            // An ack in the expiry cycle wins, so the source is still cleared.
            if (!irq_ack) begin
               if (tmo_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                  req_done            = 1'b1;
                  out_n.timeout_pulse = 1'b1;
               end else begin
                  tmo_n = tmo_q + 1'b1;
               end
            end
`endif
            if (req_done) begin
               out_n.interrupt = 1'b0;
               if (HOLDOFF_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n = HOLDOFF;
                  hold_n  = CNT_WIDTH'(HOLDOFF_CYCLES);
               end
            end
         end
         HOLDOFF: begin
            hold_n = hold_q - 1'b1;
            if (hold_q <= CNT_WIDTH'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         out_q   <= '0;
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_n;
         hold_q  <= hold_n;
         out_q   <= out_n;
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
         tmo_q   <= tmo_n;
`endif
      end
   end

   // src_q tracks the inputs even in reset so levels already high never look like edges.
   always_ff @(posedge clk) begin
      src_q <= src_irq;
      if (rst) begin
         pending <= '0;
         mask    <= MASK_RESET;
      end else begin
         pending <= (pending & ~clr) | src_edge;
         if (mask_we) mask <= mask_wdata;
      end
   end

   assign interrupt = out_q.interrupt;
   assign irq_id    = out_q.irq_id[ID_WIDTH-1:0];
`ifdef FROST32_IRQ_CTRL_TIMEOUT_EN
   assign timeout_pulse = out_q.timeout_pulse;
`endif

endmodule

// File: doc/frost32_irq_ctrl.md
# frost32_irq_ctrl

Parametrised interrupt controller between N peripheral interrupt sources and the single `interrupt` input of `Frost32Cpu`. Detects rising edges per source, latches them as pending, applies a mask, selects the lowest-numbered pending source and drives a held request with a stable source ID until the CPU acknowledges. Requests are issued only while the CPU is not stalled on memory (`wait_for_mem` low). A programmable hold-off is applied after each acknowledge.

## Interface
- `NUM_SOURCES`, 8: number of interrupt sources, 2..32.
- `ID_WIDTH`, `$clog2(NUM_SOURCES)`: width of `irq_id`.
- `HOLDOFF_CYCLES`, 2: idle cycles after an acknowledge before a new request; 0 means no hold-off.
- `MASK_RESET`, all ones: reset value of the mask register.
- `TIMEOUT_CYCLES`, 64: request timeout; used only when timeout is compiled in.
- `clk  in  1`: single clock; all state updates on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `src_irq  in  NUM_SOURCES`: level inputs from sources, synchronous to `clk`.
- `wait_for_mem  in  1`: CPU memory stall, same net as the CPU's `wait_for_mem`.
- `irq_ack  in  1`: one-cycle pulse from the CPU accepting the current request.
- `mask_we  in  1`: mask write strobe.
- `mask_wdata  in  NUM_SOURCES`: new mask; bit = 1 enables the source.
- `interrupt  out  1`: request to the CPU, registered.
- `irq_id  out  ID_WIDTH`: index of the source being requested, registered.
- `pending  out  NUM_SOURCES`: pending register.
- `mask  out  NUM_SOURCES`: mask register.

## Operation
- Edge detect: `src_q <= src_irq` every cycle. `edge = src_irq & ~src_q`. During `rst`, `src_q` loads `src_irq`, so a source already high at reset does not produce an edge.
- Pending: `pending <= (pending & ~clr) | edge`. `clr` is the one-hot `irq_id` when an acknowledge is accepted. Set wins over clear on the same bit in the same cycle.
- Candidate: `pending & mask`. The priority encoder selects the lowest set index.
- FSM states: IDLE, REQ, HOLDOFF.
  - IDLE → REQ when the candidate is nonzero and `wait_for_mem` = 0. On entry, latch `irq_id` and set `interrupt` = 1.
  - REQ: `interrupt` and `irq_id` are held stable. Mask writes and new edges do not change them.
  - REQ → HOLDOFF on `irq_ack`. Clear `pending[irq_id]`, set `interrupt` = 0 and load the hold-off counter with `HOLDOFF_CYCLES`.
  - REQ → IDLE on `irq_ack` instead of HOLDOFF when `HOLDOFF_CYCLES` = 0.
  - HOLDOFF: the counter decrements each cycle. At 1 it moves to IDLE.
- `irq_ack` outside REQ is ignored; no state or pending change.
- Mask write: `mask <= mask_wdata` the cycle after `mask_we`. Pending bits of masked sources are retained and become eligible again when unmasked.
- Reset values: `interrupt` = 0, `irq_id` = 0, `pending` = 0, `mask` = `MASK_RESET`, state = IDLE, counters = 0.
- `rst` asserted mid-REQ aborts the request. All pending bits are lost.

## Timing
- An edge at cycle t sets `pending` at t+1.
- `interrupt` rises at t+2 if the controller is IDLE, unmasked and `wait_for_mem` = 0 at t+1.
- `wait_for_mem` high blocks only the IDLE → REQ transition. An already-asserted request is not withdrawn.
- With `irq_ack` at cycle a, `interrupt` = 0 from a+1. The earliest next assertion is a+1+HOLDOFF_CYCLES+1.
- Back-to-back ack pulses: the second is ignored because the state is no longer REQ.

## Configuration
- `FROST32_IRQ_CTRL_TIMEOUT_EN` defined:
  - Adds output `timeout_pulse` (1 bit, reset 0).
  - A REQ lasting `TIMEOUT_CYCLES` cycles without `irq_ack` drops `interrupt`, pulses `timeout_pulse` for one cycle and enters HOLDOFF.
  - `pending` is not cleared, so the source is re-requested later.
  - An ack arriving in the same cycle as the timeout takes precedence.
- Not defined: no port and no counter; REQ waits indefinitely for `irq_ack`.

## Structure
- Package `PkgFrost32IrqCtrl` holds:
  - the state enum `StateIrqCtrl` (IDLE, REQ, HOLDOFF);
  - the default-parameter localparams;
  - a packed struct for the output group, following the `PortIn_`/`PortOut_` pattern.
- One sub-module, `frost32_irq_prio_enc`: combinational lowest-index encoder producing `valid` and `id` from `NUM_SOURCES` bits.

## Test plan
- Reset with `src_irq` = 8'h04 held high → `pending` = 0 and `interrupt` = 0 for 10 cycles (no spurious edge).
- Rising edges on src 5 and src 2 in the same cycle → `irq_id` = 2. After ack, following the 2-cycle hold-off, `irq_id` = 5. `pending` = 0 after the second ack.
- `wait_for_mem` = 1 with src 0 pending → `interrupt` stays 0. It rises exactly 1 cycle after `wait_for_mem` falls.
- `mask` = 8'hFE and src 0 edge → no request; `pending[0]` = 1. Write `mask` = 8'hFF → request with `irq_id` = 0.
- Src 3 re-edges in the same cycle as its ack → `pending[3]` stays 1 and a second request for id 3 follows the hold-off.
- With `FROST32_IRQ_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4 and no ack → `interrupt` high for 4 cycles, one `timeout_pulse`, then re-request with `pending` intact.
